// File: rtl/hash_host_if.sv
// Host bridge for a hash core: packs BUS_W beats into a block, starts the core, streams digest beats back; ack one cycle after load/fetch, no backpressure (ignored requests get no ack).
// Optional sticky protocol-error flag when HASH_IF_ERR_EN is defined; otherwise err is tied low.
module hash_host_if #(
    parameter int BUS_W     = 16,
    parameter int CORE_W    = 32,
    parameter int MSG_WORDS = 1,
    parameter int DIG_WORDS = 8
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic                          init,
    input  logic                          load,
    input  logic                          eom,
    input  logic                          fetch,
    input  logic [BUS_W-1:0]              idata,
    output logic                          ack,
    output logic [BUS_W-1:0]              odata,
    output logic                          core_init,
    output logic                          core_en,
    output logic                          core_last,
    output logic [MSG_WORDS*CORE_W-1:0]   core_msg,
    input  logic                          core_busy,
    input  logic [DIG_WORDS*CORE_W-1:0]   digest,
    output logic                          err
);

    localparam int MSG_W = MSG_WORDS * CORE_W;
    localparam int DIG_W = DIG_WORDS * CORE_W;
    localparam int MB    = MSG_W / BUS_W;
    localparam int DB    = DIG_W / BUS_W;
    localparam int LB_W  = (MB > 1) ? $clog2(MB) : 1;
    localparam int FB_W  = (DB > 1) ? $clog2(DB) : 1;

    typedef enum logic [1:0] {IDLE, START, WAIT} state_t;

    state_t             state_q, state_d;
    logic [LB_W-1:0]    lb_q, lb_d;
    logic [FB_W-1:0]    fb_q, fb_d;
    logic [MSG_W-1:0]   core_msg_q, core_msg_d;
    logic [BUS_W-1:0]   odata_q, odata_d;
    logic               ack_q, ack_d;
    logic               core_init_q, core_init_d;
    logic               core_en_q, core_en_d;
    logic               core_last_q, core_last_d;
    logic               err_q, err_d;

    // Digest beat 0 is the most significant BUS_W slice of word 0.
    logic [BUS_W-1:0] dig_beat [DB];
    for (genvar g = 0; g < DB; g++) begin : g_beat
        assign dig_beat[g] = digest[DIG_W-1-g*BUS_W -: BUS_W];
    end

    always_comb begin
        state_d     = state_q;
        lb_d        = lb_q;
        fb_d        = fb_q;
        core_msg_d  = core_msg_q;
        odata_d     = odata_q;
        core_last_d = core_last_q;
        err_d       = err_q;
        ack_d       = 1'b0;
        core_en_d   = 1'b0;
        core_init_d = init;

        if (init) begin
            lb_d       = '0;
            fb_d       = '0;
            core_msg_d = '0;
            err_d      = 1'b0;
            state_d    = IDLE;
        end else begin
            case (state_q)
                IDLE: begin
                    // A load wins over a same-cycle fetch.
                    if (load) begin
                        core_msg_d = MSG_W'({core_msg_q, idata});
                        ack_d      = 1'b1;
                        if (lb_q == LB_W'(MB - 1)) begin
                            lb_d        = '0;
                            core_last_d = eom;
                            core_en_d   = 1'b1;
                            state_d     = START;
                        end else begin
                            lb_d = lb_q + LB_W'(1);
                        end
                    end else if (fetch && !core_busy) begin
                        odata_d = dig_beat[fb_q];
                        ack_d   = 1'b1;
                        fb_d    = (fb_q == FB_W'(DB - 1)) ? '0 : fb_q + FB_W'(1);
                    end
                end
                START:   state_d = WAIT;
                WAIT:    if (!core_busy) state_d = IDLE;
                default: state_d = IDLE;
            endcase
            if ((load && state_q != IDLE) || (fetch && (core_busy || state_q != IDLE))
                || (load && fetch)) begin
                err_d = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            lb_q        <= '0;
            fb_q        <= '0;
            core_msg_q  <= '0;
            odata_q     <= '0;
            ack_q       <= 1'b0;
            core_init_q <= 1'b0;
            core_en_q   <= 1'b0;
            core_last_q <= 1'b0;
`ifdef HASH_IF_ERR_EN
            err_q       <= 1'b0;
`endif
        end else begin
            state_q     <= state_d;
            lb_q        <= lb_d;
            fb_q        <= fb_d;
            core_msg_q  <= core_msg_d;
            odata_q     <= odata_d;
            ack_q       <= ack_d;
            core_init_q <= core_init_d;
            core_en_q   <= core_en_d;
            core_last_q <= core_last_d;
`ifdef HASH_IF_ERR_EN
            err_q       <= err_d;
`endif
        end
    end

`ifdef HASH_IF_ERR_EN
    assign err = err_q;
`else
    assign err_q = 1'b0;
    assign err   = 1'b0;
`endif

    assign ack       = ack_q;
    assign odata     = odata_q;
    assign core_init = core_init_q;
    assign core_en   = core_en_q;
    assign core_last = core_last_q;
    assign core_msg  = core_msg_q;

endmodule
